// File: rtl/fifo_uart_tx.sv
// Drains the async FIFO in the read clock domain: pops one byte at a time
// and serialises it as an 8N1 UART frame, LSB first, on a registered line.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = 8
) (
   input  logic              rd_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rd_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              rd_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    baud_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic [DATA_W-1:0]   shift_q;
   logic                tx_q;
   logic                rd_en_q;
   logic                busy_q;
   logic                tx_done_q;
   logic                baud_last;
   logic                baud_pre_last;

   assign baud_last     = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
   assign baud_pre_last = (baud_q == CNT_W'(CLKS_PER_BIT - 2));

   // Outputs are loaded from the next state so they align with it cycle for cycle
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         rd_en_q   <= 1'b0;
         tx_done_q <= 1'b0;
         baud_q    <= baud_last ? '0 : baud_q + CNT_W'(1);
         case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               if (enable && !rd_empty) begin
                  state_q <= S_POP;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_POP: begin
               state_q <= S_LOAD;
               baud_q  <= '0;
            end
            S_LOAD: begin
               shift_q <= fifo_data;
               tx_q    <= 1'b0;
               state_q <= S_START;
               baud_q  <= '0;
            end
            S_START: begin
               if (baud_last) begin
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end
            end
            S_STOP: begin
               // Raise done one edge early so it lands on the final stop cycle
               if (baud_pre_last) begin
                  tx_done_q <= 1'b1;
               end
               if (baud_last) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_en   = rd_en_q;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
